// File: rtl/mcpu_pkg.sv
// Shared definitions for the multicycle CPU controller: ALU operation codes,
// instruction field constants, FSM state encoding and instruction classes.
package mcpu_pkg;

   // ALU operation encoding shared between controller and ALU; ADD is zero
   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_AND  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_XOR  = 4'd4,
      ALU_NOR  = 4'd5,
      ALU_SLT  = 4'd6,
      ALU_SLTU = 4'd7,
      ALU_SLL  = 4'd8,
      ALU_SRL  = 4'd9,
      ALU_SRA  = 4'd10,
      ALU_BNE  = 4'd11,
      ALU_BGTZ = 4'd12,
      ALU_BLEZ = 4'd13,
      ALU_BLTZ = 4'd14,
      ALU_LU   = 4'd15
   } alu_op_e;

   // Controller states
   typedef enum logic [3:0] {
      S_FETCH    = 4'd0,
      S_DECODE   = 4'd1,
      S_EXEC_R   = 4'd2,
      S_EXEC_I   = 4'd3,
      S_MEM_ADDR = 4'd4,
      S_MEM_RD   = 4'd5,
      S_MEM_WB   = 4'd6,
      S_MEM_WR   = 4'd7,
      S_ALU_WB   = 4'd8,
      S_BRANCH   = 4'd9,
      S_JUMP     = 4'd10
   } state_e;

   // Coarse instruction class used to pick the state after DECODE
   typedef enum logic [2:0] {
      CLS_RTYPE   = 3'd0,
      CLS_IMM     = 3'd1,
      CLS_MEM     = 3'd2,
      CLS_BRANCH  = 3'd3,
      CLS_JUMP    = 3'd4,
      CLS_ILLEGAL = 3'd5
   } instr_class_e;

   // Primary opcodes, IR[31:26]
   localparam logic [5:0] OP_RTYPE  = 6'h00;
   localparam logic [5:0] OP_REGIMM = 6'h01;
   localparam logic [5:0] OP_J      = 6'h02;
   localparam logic [5:0] OP_JAL    = 6'h03;
   localparam logic [5:0] OP_BEQ    = 6'h04;
   localparam logic [5:0] OP_BNE    = 6'h05;
   localparam logic [5:0] OP_BLEZ   = 6'h06;
   localparam logic [5:0] OP_BGTZ   = 6'h07;
   localparam logic [5:0] OP_ADDI   = 6'h08;
   localparam logic [5:0] OP_ADDIU  = 6'h09;
   localparam logic [5:0] OP_SLTI   = 6'h0A;
   localparam logic [5:0] OP_SLTIU  = 6'h0B;
   localparam logic [5:0] OP_ANDI   = 6'h0C;
   localparam logic [5:0] OP_ORI    = 6'h0D;
   localparam logic [5:0] OP_XORI   = 6'h0E;
   localparam logic [5:0] OP_LUI    = 6'h0F;
   localparam logic [5:0] OP_LW     = 6'h23;
   localparam logic [5:0] OP_SW     = 6'h2B;

   // R-type function codes, IR[5:0]
   localparam logic [5:0] F_SLL  = 6'h00;
   localparam logic [5:0] F_SRL  = 6'h02;
   localparam logic [5:0] F_SRA  = 6'h03;
   localparam logic [5:0] F_JR   = 6'h08;
   localparam logic [5:0] F_ADD  = 6'h20;
   localparam logic [5:0] F_ADDU = 6'h21;
   localparam logic [5:0] F_SUB  = 6'h22;
   localparam logic [5:0] F_SUBU = 6'h23;
   localparam logic [5:0] F_AND  = 6'h24;
   localparam logic [5:0] F_OR   = 6'h25;
   localparam logic [5:0] F_XOR  = 6'h26;
   localparam logic [5:0] F_NOR  = 6'h27;
   localparam logic [5:0] F_SLT  = 6'h2A;
   localparam logic [5:0] F_SLTU = 6'h2B;

   // Datapath mux selector encodings
   localparam logic [1:0] ASRC_PC      = 2'd0;
   localparam logic [1:0] ASRC_RS      = 2'd1;
   localparam logic [1:0] ASRC_SHAMT   = 2'd2;
   localparam logic [1:0] BSRC_RT      = 2'd0;
   localparam logic [1:0] BSRC_FOUR    = 2'd1;
   localparam logic [1:0] BSRC_IMM     = 2'd2;
   localparam logic [1:0] BSRC_IMM_SH2 = 2'd3;
   localparam logic [1:0] PCSRC_ALU    = 2'd0;
   localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
   localparam logic [1:0] PCSRC_JUMP   = 2'd2;
   localparam logic [1:0] PCSRC_RS     = 2'd3;
   localparam logic [1:0] REGDST_RT    = 2'd0;
   localparam logic [1:0] REGDST_RD    = 2'd1;
   localparam logic [1:0] REGDST_R31   = 2'd2;

   // Maps an instruction onto the execution path it takes after DECODE.
   // JR lives in the R-type space but behaves as a jump; REGIMM only
   // defines the BLTZ (rt=0) and BGEZ (rt=1) variants.
   function automatic instr_class_e classify(input logic [5:0] opcode,
                                             input logic [5:0] funct,
                                             input logic [4:0] rt);
      instr_class_e cls;
      cls = CLS_ILLEGAL;
      case (opcode)
         OP_RTYPE:  cls = (funct == F_JR) ? CLS_JUMP : CLS_RTYPE;
         OP_REGIMM: cls = (rt[4:1] == 4'd0) ? CLS_BRANCH : CLS_ILLEGAL;
         OP_J, OP_JAL: cls = CLS_JUMP;
         OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ: cls = CLS_BRANCH;
         OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU,
         OP_ANDI, OP_ORI, OP_XORI, OP_LUI: cls = CLS_IMM;
         OP_LW, OP_SW: cls = CLS_MEM;
         default: cls = CLS_ILLEGAL;
      endcase
      return cls;
   endfunction

endpackage

// File: rtl/mcpu_if.sv
// Bundle between the multicycle controller and its datapath/memory.
// The master side is the controller; the slave side is the datapath.
interface mcpu_if;
   logic [5:0] opcode;
   logic [5:0] funct;
   logic [4:0] rt;
   logic       zero;
   logic       mem_ready;

   logic       pc_write;
   logic       pc_write_cond;
   logic       i_or_d;
   logic       mem_read;
   logic       mem_write;
   logic       ir_write;
   logic       reg_write;
   logic       mem_to_reg;
   logic       ext_zero;
   logic [1:0] reg_dst;
   logic [1:0] alu_src_a;
   logic [1:0] alu_src_b;
   logic [3:0] alu_op;
   logic [1:0] pc_source;
   logic       illegal;
   logic       mem_timeout;

   modport master (
      input  opcode, funct, rt, zero, mem_ready,
      output pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
             reg_write, mem_to_reg, ext_zero, reg_dst, alu_src_a, alu_src_b,
             alu_op, pc_source, illegal, mem_timeout
   );

   modport slave (
      output opcode, funct, rt, zero, mem_ready,
      input  pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
             reg_write, mem_to_reg, ext_zero, reg_dst, alu_src_a, alu_src_b,
             alu_op, pc_source, illegal, mem_timeout
   );
endinterface

// File: rtl/mcpu_alu_dec.sv
// ALU decoder: translates opcode/funct/rt into the ALU operation, the
// immediate extension mode and a flag saying the encoding is supported.
module mcpu_alu_dec
   import mcpu_pkg::*;
(
   input  logic [5:0] opcode,
   input  logic [5:0] funct,
   input  logic [4:0] rt,
   output alu_op_e    alu_op,
   output logic       ext_zero,
   output logic       legal
);

   // Pure lookup; anything not listed is reported as not legal
   always_comb begin
      alu_op   = ALU_ADD;
      ext_zero = 1'b0;
      legal    = 1'b1;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               F_SLL:         alu_op = ALU_SLL;
               F_SRL:         alu_op = ALU_SRL;
               F_SRA:         alu_op = ALU_SRA;
               F_JR:          alu_op = ALU_ADD;
               F_ADD, F_ADDU: alu_op = ALU_ADD;
               F_SUB, F_SUBU: alu_op = ALU_SUB;
               F_AND:         alu_op = ALU_AND;
               F_OR:          alu_op = ALU_OR;
               F_XOR:         alu_op = ALU_XOR;
               F_NOR:         alu_op = ALU_NOR;
               F_SLT:         alu_op = ALU_SLT;
               F_SLTU:        alu_op = ALU_SLTU;
               default:       legal  = 1'b0;
            endcase
         end
         OP_REGIMM: begin
            alu_op = ALU_BLTZ;
            legal  = (rt[4:1] == 4'd0);
         end
         OP_J, OP_JAL, OP_LW, OP_SW: alu_op = ALU_ADD;
         OP_BEQ:   alu_op = ALU_SUB;
         OP_BNE:   alu_op = ALU_BNE;
         OP_BLEZ:  alu_op = ALU_BLEZ;
         OP_BGTZ:  alu_op = ALU_BGTZ;
         OP_ADDI, OP_ADDIU: alu_op = ALU_ADD;
         OP_SLTI:  alu_op = ALU_SLT;
         OP_SLTIU: alu_op = ALU_SLTU;
         OP_ANDI: begin
            alu_op   = ALU_AND;
            ext_zero = 1'b1;
         end
         OP_ORI: begin
            alu_op   = ALU_OR;
            ext_zero = 1'b1;
         end
         OP_XORI: begin
            alu_op   = ALU_XOR;
            ext_zero = 1'b1;
         end
         OP_LUI:   alu_op = ALU_LU;
         default:  legal  = 1'b0;
      endcase
   end

endmodule

// File: rtl/mcpu_ctrl.sv
// Multicycle CPU control FSM. Sequences fetch, decode, execute, memory and
// write-back, stalls on mem_ready and flags long memory waits. All control
// outputs are forced low while rst_n is held low. MEM_WAIT_MAX must be >= 1.
module mcpu_ctrl
   import mcpu_pkg::*;
#(
   parameter int MEM_WAIT_MAX = 15
)
(
   input logic   clk,
   input logic   rst_n,
   mcpu_if.master bus
);

   localparam int WAIT_W = $clog2(MEM_WAIT_MAX + 1);
   localparam logic [WAIT_W-1:0] WAIT_MAX  = WAIT_W'(MEM_WAIT_MAX);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_WAIT_MAX - 1);

   state_e            state_q, state_d;
   logic [WAIT_W-1:0] wait_q, wait_d;

   alu_op_e      dec_alu_op;
   logic         dec_ext_zero;
   logic         dec_legal;
   instr_class_e cls;
   logic         is_shift;

   logic       pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
   logic       reg_write, mem_to_reg, ext_zero, illegal, mem_timeout;
   logic [1:0] reg_dst, alu_src_a, alu_src_b, pc_source;
   alu_op_e    alu_op;
   logic       waiting;

   mcpu_alu_dec u_alu_dec (
      .opcode   (bus.opcode),
      .funct    (bus.funct),
      .rt       (bus.rt),
      .alu_op   (dec_alu_op),
      .ext_zero (dec_ext_zero),
      .legal    (dec_legal)
   );

   assign cls      = classify(bus.opcode, bus.funct, bus.rt);
   assign is_shift = (bus.funct == F_SLL) || (bus.funct == F_SRL) ||
                     (bus.funct == F_SRA);

   // Next state, Moore/Mealy control outputs and memory wait counting
   always_comb begin
      state_d       = state_q;
      wait_d        = '0;
      waiting       = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      i_or_d        = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      ir_write      = 1'b0;
      reg_write     = 1'b0;
      mem_to_reg    = 1'b0;
      ext_zero      = 1'b0;
      reg_dst       = REGDST_RT;
      alu_src_a     = ASRC_PC;
      alu_src_b     = BSRC_RT;
      alu_op        = ALU_ADD;
      pc_source     = PCSRC_ALU;
      illegal       = 1'b0;
      mem_timeout   = 1'b0;

      case (state_q)
         S_FETCH: begin
            mem_read  = 1'b1;
            alu_src_a = ASRC_PC;
            alu_src_b = BSRC_FOUR;
            waiting   = 1'b1;
            if (bus.mem_ready) begin
               ir_write  = 1'b1;
               pc_write  = 1'b1;
               pc_source = PCSRC_ALU;
               state_d   = S_DECODE;
            end
         end
         S_DECODE: begin
            alu_src_a = ASRC_PC;
            alu_src_b = BSRC_IMM_SH2;
            case (cls)
               CLS_RTYPE:  state_d = S_EXEC_R;
               CLS_IMM:    state_d = S_EXEC_I;
               CLS_MEM:    state_d = S_MEM_ADDR;
               CLS_BRANCH: state_d = S_BRANCH;
               CLS_JUMP:   state_d = S_JUMP;
               default: begin
                  illegal = 1'b1;
                  state_d = S_FETCH;
               end
            endcase
         end
         S_EXEC_R: begin
            alu_src_a = is_shift ? ASRC_SHAMT : ASRC_RS;
            alu_src_b = BSRC_RT;
            alu_op    = dec_alu_op;
            if (dec_legal) begin
               state_d = S_ALU_WB;
            end else begin
               illegal = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_EXEC_I: begin
            alu_src_a = ASRC_RS;
            alu_src_b = BSRC_IMM;
            alu_op    = dec_alu_op;
            ext_zero  = dec_ext_zero;
            state_d   = S_ALU_WB;
         end
         S_ALU_WB: begin
            reg_write = 1'b1;
            reg_dst   = (bus.opcode == OP_RTYPE) ? REGDST_RD : REGDST_RT;
            state_d   = S_FETCH;
         end
         S_MEM_ADDR: begin
            alu_src_a = ASRC_RS;
            alu_src_b = BSRC_IMM;
            state_d   = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
         end
         S_MEM_RD: begin
            i_or_d   = 1'b1;
            mem_read = 1'b1;
            waiting  = 1'b1;
            if (bus.mem_ready) state_d = S_MEM_WB;
         end
         S_MEM_WB: begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
            reg_dst    = REGDST_RT;
            state_d    = S_FETCH;
         end
         S_MEM_WR: begin
            i_or_d    = 1'b1;
            mem_write = 1'b1;
            waiting   = 1'b1;
            if (bus.mem_ready) state_d = S_FETCH;
         end
         S_BRANCH: begin
            alu_src_a     = ASRC_RS;
            alu_src_b     = BSRC_RT;
            alu_op        = dec_alu_op;
            pc_write_cond = 1'b1;
            pc_source     = PCSRC_ALUOUT;
            state_d       = S_FETCH;
         end
         S_JUMP: begin
            pc_write = 1'b1;
            if (bus.opcode == OP_RTYPE) begin
               pc_source = PCSRC_RS;
            end else begin
               pc_source = PCSRC_JUMP;
            end
            if (bus.opcode == OP_JAL) begin
               reg_write  = 1'b1;
               reg_dst    = REGDST_R31;
               mem_to_reg = 1'b0;
            end
            state_d = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase

      // The counter holds the number of stalled cycles in this state; the
      // pulse fires on the stall that brings it to the limit, then it sticks
      if (waiting && !bus.mem_ready) begin
         wait_d      = (wait_q == WAIT_MAX) ? wait_q : wait_q + 1'b1;
         mem_timeout = (wait_q == WAIT_LAST);
      end

      if (!rst_n) begin
         pc_write      = 1'b0;
         pc_write_cond = 1'b0;
         i_or_d        = 1'b0;
         mem_read      = 1'b0;
         mem_write     = 1'b0;
         ir_write      = 1'b0;
         reg_write     = 1'b0;
         mem_to_reg    = 1'b0;
         ext_zero      = 1'b0;
         reg_dst       = REGDST_RT;
         alu_src_a     = ASRC_PC;
         alu_src_b     = BSRC_RT;
         alu_op        = ALU_ADD;
         pc_source     = PCSRC_ALU;
         illegal       = 1'b0;
         mem_timeout   = 1'b0;
      end
   end

   // State and wait counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_FETCH;
         wait_q  <= '0;
      end else begin
         state_q <= state_d;
         wait_q  <= wait_d;
      end
   end

   assign bus.pc_write      = pc_write;
   assign bus.pc_write_cond = pc_write_cond;
   assign bus.i_or_d        = i_or_d;
   assign bus.mem_read      = mem_read;
   assign bus.mem_write     = mem_write;
   assign bus.ir_write      = ir_write;
   assign bus.reg_write     = reg_write;
   assign bus.mem_to_reg    = mem_to_reg;
   assign bus.ext_zero      = ext_zero;
   assign bus.reg_dst       = reg_dst;
   assign bus.alu_src_a     = alu_src_a;
   assign bus.alu_src_b     = alu_src_b;
   assign bus.alu_op        = alu_op;
   assign bus.pc_source     = pc_source;
   assign bus.illegal       = illegal;
   assign bus.mem_timeout   = mem_timeout;

endmodule

// File: tb/tb_mcpu_ctrl.sv
// Directed testbench for mcpu_ctrl: walks instruction sequences cycle by
// cycle and compares every control output against hand-derived values.
module tb_mcpu_ctrl;
   import mcpu_pkg::*;

   typedef struct packed {
      logic       pc_write;
      logic       pc_write_cond;
      logic       i_or_d;
      logic       mem_read;
      logic       mem_write;
      logic       ir_write;
      logic       reg_write;
      logic       mem_to_reg;
      logic       ext_zero;
      logic [1:0] reg_dst;
      logic [1:0] alu_src_a;
      logic [1:0] alu_src_b;
      logic [3:0] alu_op;
      logic [1:0] pc_source;
      logic       illegal;
      logic       mem_timeout;
   } ctrl_t;

   logic  clk;
   logic  rst_n;
   int    checks;
   int    errors;
   ctrl_t obs;
   ctrl_t e;

   mcpu_if bus ();

   mcpu_ctrl #(.MEM_WAIT_MAX(15)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   // Gather all outputs into one word for whole-vector comparison
   assign obs = {bus.pc_write, bus.pc_write_cond, bus.i_or_d, bus.mem_read,
                 bus.mem_write, bus.ir_write, bus.reg_write, bus.mem_to_reg,
                 bus.ext_zero, bus.reg_dst, bus.alu_src_a, bus.alu_src_b,
                 bus.alu_op, bus.pc_source, bus.illegal, bus.mem_timeout};

   function automatic ctrl_t exp_zero();
      ctrl_t c;
      c        = '0;
      c.alu_op = ALU_ADD;
      return c;
   endfunction

   function automatic ctrl_t exp_fetch(input logic ready);
      ctrl_t c;
      c           = exp_zero();
      c.mem_read  = 1'b1;
      c.alu_src_a = 2'd0;
      c.alu_src_b = 2'd1;
      if (ready) begin
         c.ir_write  = 1'b1;
         c.pc_write  = 1'b1;
         c.pc_source = 2'd0;
      end
      return c;
   endfunction

   function automatic ctrl_t exp_decode();
      ctrl_t c;
      c           = exp_zero();
      c.alu_src_a = 2'd0;
      c.alu_src_b = 2'd3;
      return c;
   endfunction

   function automatic ctrl_t exp_exec_r(input logic [3:0] op, input logic shift);
      ctrl_t c;
      c           = exp_zero();
      c.alu_src_a = shift ? 2'd2 : 2'd1;
      c.alu_src_b = 2'd0;
      c.alu_op    = op;
      return c;
   endfunction

   function automatic ctrl_t exp_exec_i(input logic [3:0] op, input logic ez);
      ctrl_t c;
      c           = exp_zero();
      c.alu_src_a = 2'd1;
      c.alu_src_b = 2'd2;
      c.alu_op    = op;
      c.ext_zero  = ez;
      return c;
   endfunction

   function automatic ctrl_t exp_alu_wb(input logic [1:0] dst);
      ctrl_t c;
      c           = exp_zero();
      c.reg_write = 1'b1;
      c.reg_dst   = dst;
      return c;
   endfunction

   function automatic ctrl_t exp_mem_addr();
      ctrl_t c;
      c           = exp_zero();
      c.alu_src_a = 2'd1;
      c.alu_src_b = 2'd2;
      return c;
   endfunction

   function automatic ctrl_t exp_mem_rd();
      ctrl_t c;
      c          = exp_zero();
      c.i_or_d   = 1'b1;
      c.mem_read = 1'b1;
      return c;
   endfunction

   function automatic ctrl_t exp_mem_wb();
      ctrl_t c;
      c            = exp_zero();
      c.reg_write  = 1'b1;
      c.mem_to_reg = 1'b1;
      c.reg_dst    = 2'd0;
      return c;
   endfunction

   function automatic ctrl_t exp_mem_wr();
      ctrl_t c;
      c           = exp_zero();
      c.i_or_d    = 1'b1;
      c.mem_write = 1'b1;
      return c;
   endfunction

   function automatic ctrl_t exp_branch(input logic [3:0] op);
      ctrl_t c;
      c               = exp_zero();
      c.alu_src_a     = 2'd1;
      c.alu_src_b     = 2'd0;
      c.alu_op        = op;
      c.pc_write_cond = 1'b1;
      c.pc_source     = 2'd1;
      return c;
   endfunction

   function automatic ctrl_t exp_jump(input logic [1:0] src, input logic jal);
      ctrl_t c;
      c           = exp_zero();
      c.pc_write  = 1'b1;
      c.pc_source = src;
      if (jal) begin
         c.reg_write = 1'b1;
         c.reg_dst   = 2'd2;
      end
      return c;
   endfunction

   // Drive the instruction fields and handshake inputs
   task automatic applyStimulus(input logic [5:0] op, input logic [5:0] fn,
                                input logic [4:0] rt_v, input logic zf,
                                input logic rdy);
      bus.opcode    = op;
      bus.funct     = fn;
      bus.rt        = rt_v;
      bus.zero      = zf;
      bus.mem_ready = rdy;
   endtask

   // Compare the full output word
   task automatic checkOutput(input string tag, input ctrl_t exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Compare one output bit where the rest is not pinned down
   task automatic checkBit(input string tag, input logic o, input logic x);
      checks++;
      assert (o === x) else begin
         errors++;
         $error("[TB] FAIL %s observed %b expected %b", tag, o, x);
      end
   endtask

   // Sample just after the falling edge, then move to the next falling edge
   task automatic step(input string tag, input ctrl_t exp);
      #1;
      checkOutput(tag, exp);
      @(negedge clk);
   endtask

   initial begin
      clk    = 1'b0;
      rst_n  = 1'b0;
      checks = 0;
      errors = 0;
      applyStimulus(6'h00, 6'h00, 5'd0, 1'b0, 1'b1);
      #2;
      checkOutput("reset_outputs", exp_zero());
      @(negedge clk);
      rst_n = 1'b1;

      $display("[TB] ADD r3,r1,r2");
      applyStimulus(6'h00, 6'h20, 5'd2, 1'b0, 1'b1);
      step("add_fetch", exp_fetch(1'b1));
      step("add_decode", exp_decode());
      step("add_exec", exp_exec_r(ALU_ADD, 1'b0));
      step("add_wb", exp_alu_wb(2'd1));

      $display("[TB] SLL");
      applyStimulus(6'h00, 6'h00, 5'd2, 1'b0, 1'b1);
      step("sll_fetch", exp_fetch(1'b1));
      step("sll_decode", exp_decode());
      step("sll_exec", exp_exec_r(ALU_SLL, 1'b1));
      step("sll_wb", exp_alu_wb(2'd1));

      $display("[TB] ORI");
      applyStimulus(6'h0D, 6'h15, 5'd4, 1'b0, 1'b1);
      step("ori_fetch", exp_fetch(1'b1));
      step("ori_decode", exp_decode());
      step("ori_exec", exp_exec_i(ALU_OR, 1'b1));
      step("ori_wb", exp_alu_wb(2'd0));

      $display("[TB] LW with three stall cycles");
      applyStimulus(6'h23, 6'h00, 5'd5, 1'b0, 1'b1);
      step("lw_fetch", exp_fetch(1'b1));
      step("lw_decode", exp_decode());
      step("lw_addr", exp_mem_addr());
      applyStimulus(6'h23, 6'h00, 5'd5, 1'b0, 1'b0);
      step("lw_rd_wait1", exp_mem_rd());
      step("lw_rd_wait2", exp_mem_rd());
      step("lw_rd_wait3", exp_mem_rd());
      applyStimulus(6'h23, 6'h00, 5'd5, 1'b0, 1'b1);
      step("lw_rd_done", exp_mem_rd());
      step("lw_wb", exp_mem_wb());

      $display("[TB] SW");
      applyStimulus(6'h2B, 6'h00, 5'd6, 1'b0, 1'b1);
      step("sw_fetch", exp_fetch(1'b1));
      step("sw_decode", exp_decode());
      step("sw_addr", exp_mem_addr());
      step("sw_wr", exp_mem_wr());

      $display("[TB] BGEZ");
      applyStimulus(6'h01, 6'h00, 5'd1, 1'b1, 1'b1);
      step("bgez_fetch", exp_fetch(1'b1));
      step("bgez_decode", exp_decode());
      step("bgez_branch", exp_branch(ALU_BLTZ));

      $display("[TB] BEQ");
      applyStimulus(6'h04, 6'h00, 5'd7, 1'b0, 1'b1);
      step("beq_fetch", exp_fetch(1'b1));
      step("beq_decode", exp_decode());
      step("beq_branch", exp_branch(ALU_SUB));

      $display("[TB] JAL and JR");
      applyStimulus(6'h03, 6'h00, 5'd0, 1'b0, 1'b1);
      step("jal_fetch", exp_fetch(1'b1));
      step("jal_decode", exp_decode());
      step("jal_jump", exp_jump(2'd2, 1'b1));
      applyStimulus(6'h00, 6'h08, 5'd0, 1'b0, 1'b1);
      step("jr_fetch", exp_fetch(1'b1));
      step("jr_decode", exp_decode());
      step("jr_jump", exp_jump(2'd3, 1'b0));

      $display("[TB] Unknown funct");
      applyStimulus(6'h00, 6'h3F, 5'd0, 1'b0, 1'b1);
      step("badfn_fetch", exp_fetch(1'b1));
      step("badfn_decode", exp_decode());
      #1;
      checkBit("badfn_illegal", bus.illegal, 1'b1);
      checkBit("badfn_reg_write", bus.reg_write, 1'b0);
      checkBit("badfn_mem_write", bus.mem_write, 1'b0);
      @(negedge clk);

      $display("[TB] Fetch stalled for 20 cycles");
      applyStimulus(6'h3F, 6'h00, 5'd0, 1'b0, 1'b0);
      for (int k = 1; k <= 20; k++) begin
         e             = exp_fetch(1'b0);
         e.mem_timeout = (k == 15);
         step($sformatf("fetch_wait%0d", k), e);
      end

      $display("[TB] Opcode 0x3F");
      applyStimulus(6'h3F, 6'h00, 5'd0, 1'b0, 1'b1);
      step("badop_fetch", exp_fetch(1'b1));
      e         = exp_decode();
      e.illegal = 1'b1;
      step("badop_decode", e);
      step("badop_next_fetch", exp_fetch(1'b1));

      $display("[TB] Reset during SW write");
      applyStimulus(6'h2B, 6'h00, 5'd6, 1'b0, 1'b1);
      step("swr_decode", exp_decode());
      step("swr_addr", exp_mem_addr());
      applyStimulus(6'h2B, 6'h00, 5'd6, 1'b0, 1'b0);
      step("swr_wr_wait", exp_mem_wr());
      rst_n = 1'b0;
      #1;
      checkOutput("swr_reset_drop", exp_zero());
      @(negedge clk);
      rst_n = 1'b1;
      step("swr_post_reset_fetch", exp_fetch(1'b0));
      applyStimulus(6'h00, 6'h20, 5'd0, 1'b0, 1'b1);
      step("swr_resume_fetch", exp_fetch(1'b1));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
